// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file.
package regfile_pkg;

  // Active-low and active-high enable levels.
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;
  localparam logic ENABLE   = 1'b1;
  localparam logic DISABLE  = 1'b0;

  // Width of one byte lane of the write port.
  localparam int BYTE_W = 8;

  // Clear engine state encoding.
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/regfile_clr_seq.sv
// Sequential clear engine: walks every entry once, one per cycle, and
// reports busy for exactly 2**ADDR_W cycles.
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  clr_state_t        state;
  logic [ADDR_W-1:0] cnt;

  // Clear FSM: requests are only accepted in IDLE, so a request while
  // clearing neither restarts nor queues another pass.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= DISABLE;
    end else begin
      case (state)
        IDLE: begin
          if (clr_req) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= ENABLE;
          end
        end
        CLEAR: begin
          if (&cnt) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= DISABLE;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= DISABLE;
        end
      endcase
    end
  end

  // The entry addressed by the counter is zeroed at every edge in CLEAR.
  assign clr_we   = (state == CLEAR);
  assign clr_addr = cnt;

endmodule

// File: rtl/regfile_mp.sv
// Two-read / one-write register file with byte enables, optional
// hard-wired zero entry, optional write-to-read bypass and a hardware
// clear engine.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        rd0_addr,
  output logic [DATA_W-1:0]        rd0_data,
  input  logic [ADDR_W-1:0]        rd1_addr,
  output logic [DATA_W-1:0]        rd1_data,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [DATA_W/BYTE_W-1:0] wr_be,
  input  logic                     we_,
  input  logic                     clr_req,
  output logic                     busy
);

  localparam int DATA_D = 2**ADDR_W;
  localparam int BE_W   = DATA_W / BYTE_W;

  logic [DATA_W-1:0] mem [DATA_D];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              zero_wr;
  logic              wr_hit;

  // Replace the byte lanes selected by be with the new word's lanes.
  function automatic logic [DATA_W-1:0] byte_merge(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [BE_W-1:0]   be
  );
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) begin
        res[i*BYTE_W +: BYTE_W] = new_w[i*BYTE_W +: BYTE_W];
      end
    end
    return res;
  endfunction

  regfile_clr_seq #(
    .ADDR_W (ADDR_W)
  ) u_clr_seq (
    .clk      (clk),
    .reset    (reset),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // A write is effective only when enabled, not clearing, and not aimed
  // at a hard-wired zero entry; the same condition gates the bypass.
  assign zero_wr = (ZERO_REG != 0) && (wr_addr == '0);
  assign wr_hit  = (we_ == ENABLE_) && !busy && !zero_wr;

  // Storage array: reset zeroes every entry, the clear engine owns the
  // array while busy, otherwise the byte-merged write lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DATA_D; i++) begin
        mem[i] <= '0;
      end
    end else if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_hit) begin
      mem[wr_addr] <= byte_merge(mem[wr_addr], wr_data, wr_be);
    end
  end

  // Read port 0: stored word, optionally forwarded write, zero entry last
  // so it wins over both.
  always_comb begin
    rd0_data = mem[rd0_addr];
    if ((BYPASS != 0) && wr_hit && (rd0_addr == wr_addr)) begin
      rd0_data = byte_merge(mem[rd0_addr], wr_data, wr_be);
    end
    if ((ZERO_REG != 0) && (rd0_addr == '0)) begin
      rd0_data = '0;
    end
  end

  // Read port 1: same selection as port 0, evaluated independently.
  always_comb begin
    rd1_data = mem[rd1_addr];
    if ((BYPASS != 0) && wr_hit && (rd1_addr == wr_addr)) begin
      rd1_data = byte_merge(mem[rd1_addr], wr_data, wr_be);
    end
    if ((ZERO_REG != 0) && (rd1_addr == '0)) begin
      rd1_data = '0;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: one instance with bypass and a plain entry 0,
// one with the zero register and no bypass, driven by the same stimulus.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  rd0_addr = '0;
  logic [4:0]  rd1_addr = '0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_be = '0;
  logic        we_ = 1'b1;
  logic        clr_req = 1'b0;
  logic [31:0] rd0_data, rd1_data, zrd0_data, zrd1_data;
  logic        busy, zbusy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(1)) dut (
    .clk(clk), .reset(reset),
    .rd0_addr(rd0_addr), .rd0_data(rd0_data),
    .rd1_addr(rd1_addr), .rd1_data(rd1_data),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be), .we_(we_),
    .clr_req(clr_req), .busy(busy)
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_z (
    .clk(clk), .reset(reset),
    .rd0_addr(rd0_addr), .rd0_data(zrd0_data),
    .rd1_addr(rd1_addr), .rd1_data(zrd1_data),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be), .we_(we_),
    .clr_req(clr_req), .busy(zbusy)
  );

  // Scoreboard of expected outputs, filled when stimulus is driven.
  typedef struct {
    string       nm;
    int          sel;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [4:0]  a0, a1, wa;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        we;
    logic [31:0] e0, e1, z0, z1;
  } vec_t;
  vec_t vt[7];

  task automatic expect_out(input string nm, input int sel, input logic [31:0] exp);
    sb_t e;
    e.nm = nm;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  function automatic logic [31:0] pick(input int sel);
    case (sel)
      0: return rd0_data;
      1: return rd1_data;
      2: return {31'b0, busy};
      3: return zrd0_data;
      4: return zrd1_data;
      default: return {31'b0, zbusy};
    endcase
  endfunction

  task automatic drain();
    sb_t e;
    logic [31:0] act;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      act = pick(e.sel);
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.nm, act, e.exp);
      end
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [3:0] be, input logic we,
                       input logic clr);
    rd0_addr = a0;
    rd1_addr = a1;
    wr_addr  = wa;
    wr_data  = wd;
    wr_be    = be;
    we_      = we;
    clr_req  = clr;
  endtask

  // One address pair per cycle; every entry of both instances must be 0.
  task automatic sweep_zero(input string nm);
    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      drive(5'(a), 5'(31 - a), 5'd0, 32'h0, 4'h0, 1'b1, 1'b0);
      #1;
      expect_out({nm, "_rd0"}, 0, 32'h0);
      expect_out({nm, "_rd1"}, 1, 32'h0);
      expect_out({nm, "_zrd0"}, 3, 32'h0);
      expect_out({nm, "_zrd1"}, 4, 32'h0);
      drain();
    end
  endtask

  task automatic fill_index();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      drive(5'd0, 5'd0, 5'(i), 32'(i), 4'hF, 1'b0, 1'b0);
    end
    @(negedge clk);
    we_ = 1'b1;
  endtask

  initial begin
    int n;
    bit done;

    //             a0  a1  wa  wd            be       we    e0            e1            z0            z1
    vt[0] = '{5'd3, 5'd4, 5'd3, 32'hDEADBEEF, 4'hF,    1'b0, 32'hDEADBEEF, 32'h0,        32'h0,        32'h0};
    vt[1] = '{5'd3, 5'd3, 5'd3, 32'h11223344, 4'b0101, 1'b0, 32'hDE22BE44, 32'hDE22BE44, 32'hDEADBEEF, 32'hDEADBEEF};
    vt[2] = '{5'd3, 5'd3, 5'd3, 32'hFFFFFFFF, 4'hF,    1'b1, 32'hDE22BE44, 32'hDE22BE44, 32'hDE22BE44, 32'hDE22BE44};
    vt[3] = '{5'd5, 5'd3, 5'd5, 32'h12345678, 4'h0,    1'b0, 32'h0,        32'hDE22BE44, 32'h0,        32'hDE22BE44};
    vt[4] = '{5'd5, 5'd5, 5'd5, 32'hA5A5A5A5, 4'b1000, 1'b0, 32'hA5000000, 32'hA5000000, 32'h0,        32'h0};
    vt[5] = '{5'd0, 5'd5, 5'd0, 32'hFFFFFFFF, 4'hF,    1'b0, 32'hFFFFFFFF, 32'hA5000000, 32'h0,        32'hA5000000};
    vt[6] = '{5'd0, 5'd1, 5'd0, 32'h0,        4'h0,    1'b1, 32'hFFFFFFFF, 32'h0,        32'h0,        32'h0};

    // Asynchronous reset assertion, checked before any clock edge.
    #2 reset = 1'b1;
    #1;
    expect_out("rst_busy", 2, 32'h0);
    expect_out("rst_zbusy", 5, 32'h0);
    expect_out("rst_rd0", 0, 32'h0);
    expect_out("rst_rd1", 1, 32'h0);
    drain();
    sweep_zero("rst_init");
    @(negedge clk);
    reset = 1'b0;

    // Table-driven writes, byte merges, bypass and zero-register vectors.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive(vt[i].a0, vt[i].a1, vt[i].wa, vt[i].wd, vt[i].be, vt[i].we, 1'b0);
      #1;
      expect_out($sformatf("vec%0d_rd0", i), 0, vt[i].e0);
      expect_out($sformatf("vec%0d_rd1", i), 1, vt[i].e1);
      expect_out($sformatf("vec%0d_zrd0", i), 3, vt[i].z0);
      expect_out($sformatf("vec%0d_zrd1", i), 4, vt[i].z1);
      expect_out($sformatf("vec%0d_busy", i), 2, 32'h0);
      drain();
    end

    // Mid-cycle reset with non-zero contents.
    @(negedge clk);
    drive(5'd3, 5'd5, 5'd0, 32'h0, 4'h0, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    expect_out("rst2_rd0", 0, 32'h0);
    expect_out("rst2_rd1", 1, 32'h0);
    expect_out("rst2_zrd0", 3, 32'h0);
    drain();
    @(negedge clk);
    reset = 1'b0;

    // Full clear with a dropped write and a re-pulsed request mid-clear.
    fill_index();
    @(negedge clk);
    drive(5'd0, 5'd0, 5'd0, 32'h0, 4'h0, 1'b1, 1'b1);
    #1;
    expect_out("clr_pre_busy", 2, 32'h0);
    drain();
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      drive((k == 0) ? 5'd0 : 5'(k - 1), 5'(k), 5'd7, 32'hAAAA5555, 4'hF,
            (k == 3) ? 1'b0 : 1'b1, (k == 20) ? 1'b1 : 1'b0);
      if (k == 3) rd1_addr = 5'd7;
      #1;
      expect_out($sformatf("clr%0d_busy", k), 2, 32'h1);
      expect_out($sformatf("clr%0d_zbusy", k), 5, 32'h1);
      expect_out($sformatf("clr%0d_below", k), 0, 32'h0);
      expect_out($sformatf("clr%0d_at", k), 1, (k == 3) ? 32'd7 : 32'(k));
      drain();
    end
    @(negedge clk);
    drive(5'd7, 5'd31, 5'd0, 32'h0, 4'h0, 1'b1, 1'b0);
    #1;
    expect_out("clr_end_busy", 2, 32'h0);
    expect_out("clr_end_e7", 0, 32'h0);
    expect_out("clr_end_e31", 1, 32'h0);
    drain();
    sweep_zero("clr_after");

    // Reset during clear cycle 10 aborts the clear.
    for (int i = 20; i < 26; i++) begin
      @(negedge clk);
      drive(5'd0, 5'd0, 5'(i), 32'hC0DE0000 | 32'(i), 4'hF, 1'b0, 1'b0);
    end
    @(negedge clk);
    drive(5'd22, 5'd25, 5'd0, 32'h0, 4'h0, 1'b1, 1'b1);
    #1;
    expect_out("abort_pre_e22", 0, 32'hC0DE0016);
    drain();
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      clr_req = 1'b0;
    end
    #2 reset = 1'b1;
    #1;
    expect_out("abort_busy", 2, 32'h0);
    expect_out("abort_zbusy", 5, 32'h0);
    expect_out("abort_e22", 0, 32'h0);
    expect_out("abort_e25", 1, 32'h0);
    drain();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    expect_out("abort_busy_after", 2, 32'h0);
    drain();
    sweep_zero("abort_after");

    // Clear request together with a write: write lands, then is cleared.
    @(negedge clk);
    drive(5'd2, 5'd2, 5'd2, 32'h5, 4'hF, 1'b0, 1'b1);
    #1;
    expect_out("simul_byp", 0, 32'h5);
    expect_out("simul_zold", 3, 32'h0);
    drain();
    @(negedge clk);
    drive(5'd2, 5'd2, 5'd2, 32'h0, 4'h0, 1'b1, 1'b0);
    #1;
    expect_out("simul_e2", 0, 32'h5);
    expect_out("simul_ze2", 3, 32'h5);
    expect_out("simul_busy", 2, 32'h1);
    drain();
    n = 1;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      #1;
      if (!busy) done = 1'b1;
      else n++;
    end
    if (!done) begin
      errors++;
      $display("FAIL simul_timeout: busy still %0b after 40 cycles, required 0", busy);
    end
    chk_int("simul_busy_len", n, 32);
    expect_out("simul_e2_cleared", 0, 32'h0);
    expect_out("simul_ze2_cleared", 3, 32'h0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the single-port general-purpose register file.
- Provides two asynchronous read ports and one byte-enabled write port.
- Adds an optional hard-wired zero register, optional write-to-read bypass, and a sequential hardware clear engine with a busy flag.
- Sits in the CPU decode stage as the GPR file; also reusable as the control-register bank.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- ADDR_W, 5, address width; depth DATA_D = 2**ADDR_W (derived localparam, not overridable).
- ZERO_REG, 0, when 1, entry 0 reads as zero and writes to it are dropped.
- BYPASS, 1, when 1, a same-cycle write is forwarded to a matching read port.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- rd0_addr  in  ADDR_W  read port 0 address.
- rd0_data  out  DATA_W  read port 0 data; combinational.
- rd1_addr  in  ADDR_W  read port 1 address.
- rd1_data  out  DATA_W  read port 1 data; combinational.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_be  in  DATA_W/8  byte enables, active-high; bit i covers wr_data[8i+7:8i].
- we_  in  1  write enable, active-low (0 = write).
- clr_req  in  1  request to clear the whole array; sampled at rising edge.
- busy  out  1  high while the clear engine runs.

Behaviour:
- Reset (asynchronous assertion): all DATA_D entries = 0, FSM = IDLE, clear counter = 0, busy = 0. Reset mid-clear aborts the clear; the array is zeroed anyway.
- Read:
  - rdN_data = entry[rdN_addr], combinational, zero latency.
  - ZERO_REG=1 and rdN_addr==0: returns 0 regardless of stored or bypassed value.
- Write:
  - Occurs when we_==0 and busy==0.
  - At the edge, for each i with wr_be[i]==1, entry[wr_addr] byte i = wr_data byte i; other bytes keep their value.
  - wr_be all zero: no change.
  - ZERO_REG=1 and wr_addr==0: write dropped.
  - we_==0 while busy==1: write dropped silently, no error flag.
- Bypass (BYPASS=1):
  - Applies when the write is effective this cycle (we_==0, busy==0, not a dropped zero-register write) and rdN_addr==wr_addr.
  - rdN_data = per-byte merge: wr_data byte where wr_be set, else stored byte.
  - Both ports bypass independently.
- BYPASS=0: reads show the old value until after the edge.
- Clear FSM, states IDLE and CLEAR:
  - IDLE, clr_req==1 at an edge: go to CLEAR, counter = 0, busy = 1 from that edge.
  - CLEAR: at each edge, entry[counter] = 0 and counter increments. At the edge that clears entry DATA_D-1, go to IDLE, busy = 0, counter wraps to 0.
  - busy is therefore high for exactly DATA_D cycles.
  - clr_req while in CLEAR: ignored; no restart, no queueing.
  - During CLEAR, reads return current contents: not-yet-cleared entries show old data. Reads are never bypassed from the clear engine.
- Simultaneous clr_req==1 and we_==0 in IDLE: the write commits at that edge, then clearing starts the next cycle, so the written entry ends at 0.
- busy is a registered output.

Decomposition:
- Shared package regfile_pkg holds:
  - ENABLE_/DISABLE_ (active-low) and ENABLE/DISABLE constants.
  - FSM state encoding: IDLE=1'b0, CLEAR=1'b1.
  - Byte-width constant BYTE_W=8.
- One sub-module: regfile_clr_seq, containing the clear FSM, counter, busy, and the outputs clr_we/clr_addr.
- The array, write merge, zero-register gating and bypass muxes stay in regfile_mp.

Test Plan:
- Reset behaviour: assert reset asynchronously mid-cycle -> rd0_data and rd1_data = 0 for all addresses; busy = 0 immediately, without a clock edge.
- Byte-enabled write with bypass: write 0xDEADBEEF to addr 3 with be=4'hF; next cycle write 0x11223344 with be=4'b0101 while rd0_addr=3 -> rd0_data = 0xDE22BE44 in the same cycle; after the edge rd1_addr=3 -> 0xDE22BE44.
- Zero register: with ZERO_REG=1, write 0xFFFFFFFF to addr 0 -> rd0_data at addr 0 = 0 both before and after the edge. With ZERO_REG=0, the same write -> 0xFFFFFFFF after the edge.
- Clear sequence and timing (ADDR_W=5): fill all 32 entries with their index; pulse clr_req -> busy high for exactly 32 cycles. At clear cycle k, entries <k read 0 and entries >=k read their index. After busy falls, all entries read 0.
- Writes and clear requests during clear: we_=0 to addr 7 with 0xAAAA5555 during busy -> entry stays 0 after the clear. clr_req re-pulsed during busy -> busy length unchanged at 32.
- Reset mid-clear and simultaneous events:
  - Assert reset at clear cycle 10 -> busy = 0 immediately and all entries 0.
  - clr_req together with a write of 0x5 to addr 2 -> entry 2 = 5 for one cycle, then 0 after the clear completes.
